bus_master_arb: RTL
===================

// Module: bus_master_arb
// PURPOSE
//  Two-master arbiter and sequencer for the shared register bus. Grants one of
//  two requesters (m0: CPU, m1: DMA/boot loader) round-robin, issues a single
//  read or write strobe to the slaves, and waits for the OR'd rd/wr ack.
//  Returns the read data (or a timeout error) to the granted master.
//  Sits between the masters and the bus_in/bus_out fabric that slaves such as
//  ROM/RAM/regs decode.
// PARAMETERS
//  ADDR_WIDTH  32   bus byte address width
//  TIMEOUT     255  max WAIT cycles without ack before error (>=1)
// PORTS
//  bus_clk      in   1   bus clock
//  bus_reset_l  in   1   asynchronous active-low reset
//  m0_req       in   1   m0 transfer request; level, held until m0_ack
//  m0_we        in   1   1=write, 0=read; stable while m0_req
//  m0_addr      in   AW  m0 byte address; stable while m0_req
//  m0_wr_data   in   32  m0 write data; stable while m0_req
//  m0_ack       out  1   1-cycle completion pulse
//  m0_err       out  1   valid with m0_ack; 1=timed out
//  m0_rd_data   out  32  read data, valid with m0_ack (0 on write/err)
//  m1_*         --   --  identical set for master 1
//  bus_addr     out  AW  registered address to slaves
//  bus_wr_data  out  32  registered write data
//  bus_re       out  1   1-cycle read strobe
//  bus_we       out  1   1-cycle write strobe
//  bus_rd_data  in   32  OR'd slave read data (0 when no ack)
//  bus_rd_ack   in   1   OR'd slave read ack
//  bus_wr_ack   in   1   OR'd slave write ack
//  grant        out  1   index of master owning the bus (valid when busy)
//  busy         out  1   1 in ISSUE/WAIT/DONE
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, last-grant pointer=1 (m0 wins first tie).
//    Reset mid-transfer aborts silently; no ack/err is issued afterwards.
//  - FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//  - IDLE: if any req, pick winner (only requester, or on tie the master not
//    last granted); latch addr/wr_data/we/grant; update pointer; go ISSUE.
//  - ISSUE (1 cycle): bus_re or bus_we =1 per latched we; load timeout count.
//  - WAIT: strobes 0; bus_addr/bus_wr_data held. Matching ack (rd_ack for
//    read, wr_ack for write) sampled in ISSUE or WAIT -> DONE, capture
//    bus_rd_data for reads. Non-matching or IDLE/DONE acks ignored.
//  - Timeout: after TIMEOUT WAIT cycles with no ack -> DONE with err=1,
//    rd_data=0. Ack on the expiring cycle wins (err=0).
//  - DONE (1 cycle): mN_ack=1 for granted master only, with err/rd_data;
//    requests not sampled. Master must drop req on the edge it samples ack.
//  - Latency: req seen in IDLE at cycle 0 -> strobe cycle 1 -> registered
//    slave ack cycle 2 -> mN_ack cycle 3. Throughput 1 transfer / 4 cycles.
//  - No preemption; other master's req waits in place, never dropped.
//  - mN_rd_data/err hold last value between acks; only ack qualifies them.
// TESTING
//  1. m0 read 0x0000_0010, slave ack 1 cycle after re, data 0x1234_5678 ->
//     bus_re pulse cycle 1, m0_ack cycle 3, m0_rd_data=0x1234_5678, err=0.
//  2. m1 write 0x100 data 0xCAFEBABE, wr_ack -> bus_we 1 cycle,
//     bus_wr_data=0xCAFEBABE, m1_ack, m1_rd_data=0.
//  3. m0,m1 req same cycle from reset, repeated 4 times -> grants m0,m1,m0,m1.
//  4. Read unmapped addr, no ack, TIMEOUT=8 -> m0_ack 8 WAIT cycles after
//     ISSUE, m0_err=1, rd_data=0; ack on cycle 8 instead -> err=0.
//  5. Spurious rd_ack in IDLE and wr_ack during a read -> ignored, no ack.
//  6. Assert reset_l=0 during WAIT -> outputs 0 immediately; no later ack;
//     next req after release served normally, m0 priority restored.

Source files
------------

// File: rtl/bus_master_arb.sv
// Two-master round-robin arbiter and single-transfer sequencer for the shared
// register bus: grants a master, strobes the slaves once, waits for ack or timeout.
module bus_master_arb #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  bus_clk,
    input  logic                  bus_reset_l,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [31:0]           m0_wr_data,
    output logic                  m0_ack,
    output logic                  m0_err,
    output logic [31:0]           m0_rd_data,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [31:0]           m1_wr_data,
    output logic                  m1_ack,
    output logic                  m1_err,
    output logic [31:0]           m1_rd_data,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [31:0]           bus_wr_data,
    output logic                  bus_re,
    output logic                  bus_we,
    input  logic [31:0]           bus_rd_data,
    input  logic                  bus_rd_ack,
    input  logic                  bus_wr_ack,
    output logic                  grant,
    output logic                  busy
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                state_r, state_s;
    logic [CW-1:0]         cnt_r, cnt_s;
    logic                  we_r, we_s;
    logic                  last_r, last_s;
    logic                  grant_r, grant_s;
    logic [ADDR_WIDTH-1:0] addr_r, addr_s;
    logic [31:0]           wdata_r, wdata_s;
    logic                  re_r, re_s;
    logic                  bwe_r, bwe_s;
    logic                  busy_r, busy_s;
    logic                  ack0_r, ack0_s, err0_r, err0_s;
    logic                  ack1_r, ack1_s, err1_r, err1_s;
    logic [31:0]           rdd0_r, rdd0_s, rdd1_r, rdd1_s;
    logic                  match_s, pick_s, fin_s, fin_err_s;
    logic [31:0]           fin_data_s;

    // Only the ack type matching the latched direction can complete a transfer
    assign match_s = we_r ? bus_wr_ack : bus_rd_ack;

    // Next-state, arbitration and next values of every registered output
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        we_s      = we_r;
        last_s    = last_r;
        grant_s   = grant_r;
        addr_s    = addr_r;
        wdata_s   = wdata_r;
        re_s      = 1'b0;
        bwe_s     = 1'b0;
        pick_s    = 1'b0;
        fin_s     = 1'b0;
        fin_err_s = 1'b0;
        ack0_s    = 1'b0;
        err0_s    = err0_r;
        rdd0_s    = rdd0_r;
        ack1_s    = 1'b0;
        err1_s    = err1_r;
        rdd1_s    = rdd1_r;
        case (state_r)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    if (m0_req && m1_req) begin
                        pick_s = ~last_r;
                    end else begin
                        pick_s = m1_req;
                    end
                    grant_s = pick_s;
                    last_s  = pick_s;
                    we_s    = pick_s ? m1_we      : m0_we;
                    addr_s  = pick_s ? m1_addr    : m0_addr;
                    wdata_s = pick_s ? m1_wr_data : m0_wr_data;
                    re_s    = ~we_s;
                    bwe_s   = we_s;
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (match_s) begin
                    fin_s   = 1'b1;
                    state_s = ST_DONE;
                end else begin
                    cnt_s   = CW'(TIMEOUT);
                    state_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // An ack arriving on the expiring cycle still counts as success
                if (match_s) begin
                    fin_s   = 1'b1;
                    state_s = ST_DONE;
                end else if (cnt_r == CW'(1)) begin
                    fin_s     = 1'b1;
                    fin_err_s = 1'b1;
                    state_s   = ST_DONE;
                end else begin
                    cnt_s = cnt_r - CW'(1);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        fin_data_s = (fin_err_s || we_r) ? 32'd0 : bus_rd_data;
        if (fin_s && !grant_r) begin
            ack0_s = 1'b1;
            err0_s = fin_err_s;
            rdd0_s = fin_data_s;
        end else if (fin_s && grant_r) begin
            ack1_s = 1'b1;
            err1_s = fin_err_s;
            rdd1_s = fin_data_s;
        end else begin
            ack0_s = 1'b0;
            ack1_s = 1'b0;
        end
        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers; reset aborts any transfer and favours m0 next
    always_ff @(posedge bus_clk or negedge bus_reset_l) begin
        if (!bus_reset_l) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            we_r    <= 1'b0;
            last_r  <= 1'b1;
            grant_r <= 1'b0;
            addr_r  <= '0;
            wdata_r <= 32'd0;
            re_r    <= 1'b0;
            bwe_r   <= 1'b0;
            busy_r  <= 1'b0;
            ack0_r  <= 1'b0;
            err0_r  <= 1'b0;
            rdd0_r  <= 32'd0;
            ack1_r  <= 1'b0;
            err1_r  <= 1'b0;
            rdd1_r  <= 32'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            we_r    <= we_s;
            last_r  <= last_s;
            grant_r <= grant_s;
            addr_r  <= addr_s;
            wdata_r <= wdata_s;
            re_r    <= re_s;
            bwe_r   <= bwe_s;
            busy_r  <= busy_s;
            ack0_r  <= ack0_s;
            err0_r  <= err0_s;
            rdd0_r  <= rdd0_s;
            ack1_r  <= ack1_s;
            err1_r  <= err1_s;
            rdd1_r  <= rdd1_s;
        end
    end

    assign m0_ack      = ack0_r;
    assign m0_err      = err0_r;
    assign m0_rd_data  = rdd0_r;
    assign m1_ack      = ack1_r;
    assign m1_err      = err1_r;
    assign m1_rd_data  = rdd1_r;
    assign bus_addr    = addr_r;
    assign bus_wr_data = wdata_r;
    assign bus_re      = re_r;
    assign bus_we      = bwe_r;
    assign grant       = grant_r;
    assign busy        = busy_r;
endmodule
